// File: rtl/shift_deserializer_if.sv
// Bus bundle for shift_deserializer: serial input handshake, parallel output handshake, overrun flag.
// Signal suffixes are relative to the deserializer; it connects through the slave modport.
interface shift_deserializer_if #(
   parameter int TO = 100
);
   logic          data_i;
   logic          valid_i;
   logic          ready_o;
   logic [TO-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
   logic          overrun_o;

   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, data_o, valid_o, overrun_o
   );

   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o, overrun_o
   );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter: gathers TO bits MSB-first into one word and offers it
// on a valid/ready handshake; a bit presented while a word is held is dropped and flagged.
module shift_deserializer #(
   parameter int TO     = 100,
   parameter int LOG2TO = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   shift_deserializer_if.slave  bus
);
   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [LOG2TO-1:0] LAST_CNT = LOG2TO'(TO - 1);

   state_t            state_q, state_d;
   logic [TO-1:0]     shreg_q, shreg_d;
   logic [LOG2TO-1:0] cnt_q,   cnt_d;
   logic [TO-1:0]     data_q,  data_d;
   logic              ovr_q,   ovr_d;
   logic              ready_o;
   logic              valid_o;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= COLLECT;
         shreg_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
      case (state_q)
         COLLECT: begin
            if (bus.valid_i) begin
               shreg_d = {shreg_q[TO-2:0], bus.data_i};
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  data_d  = {shreg_q[TO-2:0], bus.data_i};
                  state_d = HOLD;
               end else begin
                  cnt_d = cnt_q + LOG2TO'(1);
               end
            end
         end
         HOLD: begin
            // ready_o is low here, so any offered bit is lost even if the word is leaving.
            if (bus.valid_i) ovr_d = 1'b1;
            if (bus.ready_i) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      ready_o = (state_q == COLLECT);
      valid_o = (state_q == HOLD);
   end

   assign bus.ready_o   = ready_o;
   assign bus.valid_o   = valid_o;
   assign bus.data_o    = data_q;
   assign bus.overrun_o = ovr_q;
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-to-parallel converter: collects TO serial bits, MSB-first, into one TO-bit word.
- Presents the word on a valid/ready output handshake.
- Receive-side counterpart of the team's shift-register serializer. Sits at the far end of a 1-bit link and restores the parallel datapath word.
- Single clock domain; no CDC.

Parameters:
- TO, 100, word width in bits; the number of serial bits per word. Must be ≥ 2.
- LOG2TO, 8, bit counter width. Must satisfy 2^LOG2TO > TO-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_i  in  1  serial data bit; sampled when valid_i && ready_o.
- valid_i  in  1  data_i carries a valid bit this cycle.
- ready_o  out  1  block accepts a serial bit this cycle.
- data_o  out  TO  assembled word, registered; stable while valid_o=1.
- valid_o  out  1  data_o holds a complete word.
- ready_i  in  1  downstream accepts the word this cycle.
- overrun_o  out  1  sticky flag: valid_i was asserted while ready_o=0.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream) sets:
  - state COLLECT
  - shift register and bit counter to 0
  - data_o = 0, valid_o = 0, ready_o = 1, overrun_o = 0
- FSM states: COLLECT, HOLD.
- COLLECT:
  - ready_o=1, valid_o=0.
  - On a cycle with valid_i=1: shreg <= {shreg[TO-2:0], data_i}, so the first bit received ends up in data_o[TO-1].
  - On the same cycle: if cnt == TO-1 then cnt <= 0; else cnt <= cnt+1.
  - valid_i=0 cycles are gaps: no shift, no count change. Gaps of any length are legal.
  - When the accepted bit has cnt == TO-1: data_o <= {shreg[TO-2:0], data_i} and the next state is HOLD.
- HOLD:
  - ready_o=0, valid_o=1; data_o and the shift register are frozen.
  - If ready_i=1: handshake completes; next state is COLLECT, valid_o drops the following cycle.
  - If ready_i=0: stay in HOLD indefinitely.
- Latency:
  - Last bit accepted in cycle N → valid_o=1 and data_o correct from cycle N+1.
  - Earliest acceptance of the first bit of the next word is cycle N+2, given ready_i=1 in N+1.
  - Sustained throughput: TO+1 cycles per word.
- ready_o is a combinational decode of state only; it does not depend on valid_i or ready_i.
- valid_o and data_o are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Overrun:
  - valid_i=1 while in HOLD → the bit is dropped and overrun_o <= 1.
  - overrun_o stays set until reset; the current word is unaffected.
- Simultaneous events: a ready_i=1 and valid_i=1 in the same HOLD cycle still drops the bit and sets overrun, because ready_o=0 that cycle.
- Reset mid-frame: a partial word is discarded and the counter restarts at 0. The first bit after reset release is bit TO-1 of a new word.
- Reset in HOLD: the word is lost and valid_o goes to 0 immediately (asynchronously).
- Counter wrap: cnt never exceeds TO-1; no other wrap state exists.

Test Plan (TO=8, LOG2TO=3 unless stated):
- Basic: after reset, drive bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles with valid_i=1 and ready_i=1 → valid_o=1 for exactly 1 cycle, the cycle after the 8th bit, with data_o=8'hA5; ready_o=0 during that cycle; overrun_o=0.
- Gapped input: same bits as Basic, with valid_i=0 for 3 cycles after bit 2 and 1 cycle after bit 6 → data_o=8'hA5, valid_o rises the cycle after the 8th accepted bit; the gaps change nothing.
- Backpressure and overrun:
  - Send 8'h3C with ready_i=0 for 4 cycles after valid_o rises → valid_o=1 and data_o=8'h3C held for 4 cycles, ready_o=0 throughout.
  - Assert valid_i in the 2nd HOLD cycle → overrun_o=1 from the next cycle and stays set.
  - Raise ready_i → valid_o=0 the next cycle; a subsequent 8'hFF frame is received correctly.
- Back-to-back: with ready_i tied 1, stream 8'h01 then 8'h80, respecting ready_o → two words 8'h01 and 8'h80, valid_o pulses 9 cycles apart, overrun_o=0.
- Reset mid-operation:
  - Send 5 bits, pulse reset_n low for 1 cycle, then send 8'hC3 → valid_o only after the 8 post-reset bits, data_o=8'hC3.
  - Reset during HOLD → valid_o drops asynchronously, data_o=0.
- Default parameters (TO=100, LOG2TO=8): random 100-bit word sent MSB-first, with random valid_i gaps and random ready_i stalls → every received word matches the sent word, for at least 50 words.
